// File: rtl/pinmux_sel_ctrl.sv
// Break-before-make select controller feeding the pinmux output multiplexer.
// Optional sticky lock is enabled by defining PINMUX_SEL_LOCK_EN.
module pinmux_sel_ctrl #(
    parameter int NUM_PERIPHERALS = 4,
    parameter int SEL_WIDTH       = 5,
    parameter int DEAD_CYCLES     = 2,
    parameter int SETTLE_CYCLES   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_valid,
    input  logic [SEL_WIDTH-1:0] i_wr_sel,
    output logic                 o_wr_ready,
    input  logic                 i_lock,
    output logic [SEL_WIDTH-1:0] o_sel,
    output logic                 o_oe_gate,
    output logic                 o_wr_done,
    output logic                 o_err,
    output logic                 o_locked
);

    localparam int MAX_CYC = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0] target_q, target_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 gate_q, gate_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 locked_q, locked_d;
    logic                 lock_req;
    logic                 hi_bits;
    logic                 multi_bits;
    logic                 sel_bad;

`ifdef PINMUX_SEL_LOCK_EN
    assign lock_req = i_lock;
`else
    logic unused_lock;
    assign unused_lock = i_lock;
    assign lock_req    = 1'b0;
`endif

    // A write is malformed if it names a peripheral that does not exist or more than one.
    always_comb begin
        hi_bits = 1'b0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            if (i >= NUM_PERIPHERALS) hi_bits = hi_bits | i_wr_sel[i];
        end
        multi_bits = |(i_wr_sel & (i_wr_sel - SEL_WIDTH'(1)));
        sel_bad    = hi_bits | multi_bits;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        sel_d    = sel_q;
        gate_d   = gate_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q | lock_req;
        case (state_q)
            ST_IDLE: begin
                if (i_wr_valid) begin
                    if (locked_q || sel_bad) begin
                        err_d = 1'b1;
                    end else if (i_wr_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = i_wr_sel;
                        cnt_d    = CW'(DEAD_CYCLES);
                        state_d  = ST_DRAIN;
                        gate_d   = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q <= CW'(1)) begin
                    sel_d = target_q;
                    if (SETTLE_CYCLES > 0) begin
                        state_d = ST_SETTLE;
                        cnt_d   = CW'(SETTLE_CYCLES);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        gate_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    gate_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gate_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            sel_q    <= '0;
            gate_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            sel_q    <= sel_d;
            gate_q   <= gate_d;
            done_q   <= done_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign o_wr_ready = (state_q == ST_IDLE);
    assign o_sel      = sel_q;
    assign o_oe_gate  = gate_q;
    assign o_wr_done  = done_q;
    assign o_err      = err_q;
    assign o_locked   = locked_q;

endmodule

// File: tb/tb_pinmux_sel_ctrl.sv
// Bench for pinmux_sel_ctrl: directed and random writes checked against a timeline model.
// Lock expectations follow whether PINMUX_SEL_LOCK_EN is defined.
module tb_pinmux_sel_ctrl;

    localparam int NP = 4;
    localparam int SW = 5;
    localparam int DC = 2;
    localparam int SC = 1;
`ifdef PINMUX_SEL_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_wr_valid;
    logic [SW-1:0] i_wr_sel;
    logic          o_wr_ready;
    logic          i_lock;
    logic [SW-1:0] o_sel;
    logic          o_oe_gate;
    logic          o_wr_done;
    logic          o_err;
    logic          o_locked;

    always #5 clk = ~clk;

    pinmux_sel_ctrl #(
        .NUM_PERIPHERALS(NP),
        .SEL_WIDTH      (SW),
        .DEAD_CYCLES    (DC),
        .SETTLE_CYCLES  (SC)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_wr_valid(i_wr_valid),
        .i_wr_sel  (i_wr_sel),
        .o_wr_ready(o_wr_ready),
        .i_lock    (i_lock),
        .o_sel     (o_sel),
        .o_oe_gate (o_oe_gate),
        .o_wr_done (o_wr_done),
        .o_err     (o_err),
        .o_locked  (o_locked)
    );

    typedef struct packed {
        logic [SW-1:0] sel;
        logic          gate;
        logic          done;
        logic          err;
        logic          ready;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    logic [SW-1:0] sel_m;
    bit            locked_m;
    exp_t          exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".sel"},    32'(o_sel),      32'(e.sel));
        check({tag, ".gate"},   32'(o_oe_gate),  32'(e.gate));
        check({tag, ".done"},   32'(o_wr_done),  32'(e.done));
        check({tag, ".err"},    32'(o_err),      32'(e.err));
        check({tag, ".ready"},  32'(o_wr_ready), 32'(e.ready));
        check({tag, ".locked"}, 32'(o_locked),   32'(locked_m));
    endtask

    function automatic bit is_bad(input logic [SW-1:0] s);
        return ($countones(s) > 1) || ((s >> NP) != 0);
    endfunction

    // Expected per-cycle outputs after an accepted write, from the timing rules.
    task automatic build_trace(input logic [SW-1:0] s, input bit tail);
        exp_q.delete();
        if (locked_m || is_bad(s)) begin
            exp_q.push_back(exp_t'{sel_m, 1'b1, 1'b0, 1'b1, 1'b1});
            exp_q.push_back(exp_t'{sel_m, 1'b1, 1'b0, 1'b0, 1'b1});
        end else if (s == sel_m) begin
            exp_q.push_back(exp_t'{sel_m, 1'b1, 1'b1, 1'b0, 1'b1});
            if (tail) exp_q.push_back(exp_t'{sel_m, 1'b1, 1'b0, 1'b0, 1'b1});
        end else begin
            for (int i = 0; i < DC; i++) exp_q.push_back(exp_t'{sel_m, 1'b0, 1'b0, 1'b0, 1'b0});
            for (int i = 0; i < SC; i++) exp_q.push_back(exp_t'{s, 1'b0, 1'b0, 1'b0, 1'b0});
            exp_q.push_back(exp_t'{s, 1'b1, 1'b1, 1'b0, 1'b1});
            if (tail) exp_q.push_back(exp_t'{s, 1'b1, 1'b0, 1'b0, 1'b1});
            sel_m = s;
        end
    endtask

    // Called at a negedge with the DUT idle; the write is accepted at the next posedge.
    task automatic issue(input string tag, input logic [SW-1:0] s, input int lock_at,
                         input int hold_at, input logic [SW-1:0] hold_sel);
        exp_t e;
        int   k;
        i_wr_valid = 1'b1;
        i_wr_sel   = s;
        build_trace(s, hold_at < 0);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            if (k == 0) i_wr_valid = 1'b0;
            check_outputs(tag, e);
            i_lock = (k == lock_at);
            if (k == lock_at) locked_m = locked_m | LOCK_EN;
            if (k == hold_at) begin
                i_wr_valid = 1'b1;
                i_wr_sel   = hold_sel;
            end
            k++;
        end
    endtask

    initial begin
        logic [SW-1:0] s;
        int            r;

        i_rst_n    = 1'b0;
        i_wr_valid = 1'b0;
        i_wr_sel   = '0;
        i_lock     = 1'b0;
        sel_m      = '0;
        locked_m   = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset", exp_t'{5'b00000, 1'b1, 1'b0, 1'b0, 1'b1});
        i_rst_n = 1'b1;
        @(negedge clk);
        check_outputs("post_reset", exp_t'{5'b00000, 1'b1, 1'b0, 1'b0, 1'b1});

        issue("switch_00100", 5'b00100, -1, -1, '0);
        issue("err_multi", 5'b00110, -1, -1, '0);
        issue("err_high", 5'b10000, -1, -1, '0);
        issue("same_sel", 5'b00100, -1, -1, '0);
        issue("held_first", 5'b00010, -1, 0, 5'b00001);
        issue("held_second", 5'b00001, -1, -1, '0);
        issue("back_00100", 5'b00100, -1, -1, '0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 4);
            case (r)
                0:       s = '0;
                1:       s = SW'(1) << $urandom_range(0, NP - 1);
                2:       s = sel_m;
                3:       s = SW'(1) << $urandom_range(NP, SW - 1);
                default: s = SW'($urandom_range(0, (1 << SW) - 1));
            endcase
            issue("rand", s, -1, -1, '0);
        end

        i_wr_valid = 1'b1;
        i_wr_sel   = (sel_m == 5'b00010) ? 5'b01000 : 5'b00010;
        @(negedge clk);
        i_wr_valid = 1'b0;
        check("rst_mid.pre_gate", 32'(o_oe_gate), 32'd0);
        check("rst_mid.pre_ready", 32'(o_wr_ready), 32'd0);
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n  = 1'b1;
        sel_m    = '0;
        locked_m = 1'b0;
        check_outputs("rst_mid", exp_t'{5'b00000, 1'b1, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        check_outputs("rst_after", exp_t'{5'b00000, 1'b1, 1'b0, 1'b0, 1'b1});

        issue("lock_switch", 5'b00100, DC, -1, '0);
        issue("lock_write", 5'b00001, -1, -1, '0);
        issue("lock_write2", 5'b00010, -1, -1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pinmux_sel_ctrl.md
# pinmux_sel_ctrl

Sequential select controller directly upstream of the pinmux output multiplexer. It accepts one-hot peripheral-select writes through a valid/ready port and drives the multiplexer's select vector. Each ownership change runs a break-before-make sequence: it gates pad output-enable low, holds the old select for a dead time, switches to the new select, waits a settle time, then releases the gate. An optional lock freezes the selection until reset.

## Interface
- `NUM_PERIPHERALS`, 4: number of selectable peripherals; bits at and above this index in a write must be 0.
- `SEL_WIDTH`, 5: width of the select vector; one bit per peripheral. Must be ≥ `NUM_PERIPHERALS`.
- `DEAD_CYCLES`, 2: cycles in DRAIN, gate low with the old select held; legal range ≥ 1.
- `SETTLE_CYCLES`, 1: cycles in SETTLE, gate low with the new select driven; legal range ≥ 0.

Ports:
- `i_clk`, input, 1: clock. Single clock domain.
- `i_rst_n`, input, 1: synchronous, active-low reset.
- `i_wr_valid`, input, 1: write request.
- `i_wr_sel`, input, SEL_WIDTH: requested select. Must be one-hot or all-zero; all-zero means no peripheral owns the pad.
- `o_wr_ready`, output, 1: write is accepted on any edge where valid and ready are both high.
- `i_lock`, input, 1: lock request. Sampled every cycle.
- `o_sel`, output, SEL_WIDTH: select vector to the multiplexer. Registered.
- `o_oe_gate`, output, 1: active-high enable gate. The pad wrapper ANDs it with the multiplexer OE. Registered.
- `o_wr_done`, output, 1: one-cycle pulse marking completion of an accepted write.
- `o_err`, output, 1: one-cycle pulse marking a rejected write.
- `o_locked`, output, 1: lock state.

## Operation
- States: IDLE, DRAIN, SETTLE. A down-counter sized `$clog2(max(DEAD_CYCLES,SETTLE_CYCLES)+1)` times DRAIN and SETTLE.
- Reset values: state IDLE, `o_sel`=0, `o_oe_gate`=1, `o_wr_ready`=1, `o_wr_done`=0, `o_err`=0, `o_locked`=0, counter 0. No pending target survives reset.
- `o_wr_ready` is 1 exactly while in IDLE.
- On an accepted write in IDLE, the first matching case below applies:
  - Locked: the write is dropped, `o_err` pulses, state stays IDLE.
  - `i_wr_sel` has more than one bit set, or a bit at index ≥ `NUM_PERIPHERALS`: the write is dropped and `o_err` pulses.
  - `i_wr_sel` equals `o_sel`: no transition; `o_wr_done` pulses on the next cycle.
  - Otherwise: the target is latched, the FSM enters DRAIN with count `DEAD_CYCLES`, and `o_oe_gate` goes 0.
- DRAIN: `o_sel` holds the old value and the counter decrements. When the count expires, the FSM loads the target into `o_sel`. It then enters SETTLE if `SETTLE_CYCLES` > 0, otherwise IDLE.
- SETTLE: the gate stays 0. When the count expires, the FSM enters IDLE.
- Entering IDLE from DRAIN or SETTLE sets `o_oe_gate`=1 and pulses `o_wr_done`.
- Lock: the first cycle with `i_lock`=1 sets `o_locked`=1 (sticky). Only reset clears it.
- A lock asserted mid-transition does not abort the transition. The in-flight write completes normally.
- Writes with `i_wr_valid` high while busy are not accepted. The master must hold the request until ready.

## Timing
- Write accepted at edge N; switching case:
  - Edges N+1 … N+DEAD_CYCLES: gate=0, old select.
  - From edge N+DEAD_CYCLES+1: new select.
  - Edge N+DEAD_CYCLES+SETTLE_CYCLES+1: gate=1, `o_wr_done`=1, ready=1.
- Total busy time: DEAD_CYCLES+SETTLE_CYCLES cycles.
- Back-to-back writes are possible: a new write can be accepted on the same edge that `o_wr_done` rises.
- No-change write accepted at edge N: `o_wr_done`=1 at edge N+1. The gate never drops.
- Rejected write accepted at edge N: `o_err`=1 at edge N+1 and clears at N+2. No other output changes.
- `o_oe_gate` is 0 for the entire interval in which `o_sel` differs from its pre-write value at any point.
- At no edge do gate=1 and a select change occur together.
- `i_rst_n` low at any edge, including mid-DRAIN or mid-SETTLE: the next cycle shows all outputs at their reset values.

## Configuration
- `PINMUX_SEL_LOCK_EN` defined: `i_lock` and `o_locked` behave as described above.
- `PINMUX_SEL_LOCK_EN` undefined: `i_lock` is ignored and `o_locked` is tied 0. Locked-write rejection never occurs. Port list is unchanged.

## Test plan
- Reset, then write 5'b00100 with DEAD=2, SETTLE=1 → gate 0 for 3 cycles; `o_sel`=00000 for 2 cycles, then 00100; `o_wr_done` pulse on cycle 4; gate back to 1.
- Write 5'b00110 → `o_err` single pulse; `o_sel` and gate unchanged. Repeat with 5'b10000 and `NUM_PERIPHERALS`=4 → same result.
- Write 00100, then write 00100 again → second write gives `o_wr_done` one cycle after acceptance; gate stays 1.
- Hold `i_wr_valid` with 00001 while mid-DRAIN → ready=0 until done. Then it is accepted, and the full sequence restarts from select 00100.
- With the macro defined, pulse `i_lock` mid-SETTLE → the transition completes, `o_locked`=1, and the next write gives `o_err` with select unchanged. Without the macro, the same stimulus gives `o_locked`=0 and the write succeeds.
- Deassert `i_rst_n` during DRAIN → next cycle `o_sel`=0, gate=1, ready=1, no `o_wr_done` pulse.
